// File: rtl/iddmm_pkg.sv
// rtl/iddmm_pkg.sv - shared types and constants for the IDDMM divider
package iddmm_pkg;

  localparam int IDDMM_DW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of a counter that must hold the value 2*dw (one iteration per dividend bit)
  function automatic int cnt_width(input int dw);
    return $clog2(2 * dw) + 1;
  endfunction

endpackage

// File: rtl/iddmm_lzc.sv
// rtl/iddmm_lzc.sv - parameterised leading-zero counter (all-zero input returns W)
module iddmm_lzc #(
  parameter int W  = 256,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count
);

  // Scan upward so the highest set bit is the last one to overwrite the count
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/iddmm_div_256_by_128.sv
// rtl/iddmm_div_256_by_128.sv - radix-2 restoring 2*DW/DW divider, optional IDDMM_DIV_EARLY_TERM_EN
module iddmm_div_256_by_128
  import iddmm_pkg::*;
#(
  parameter int DW = IDDMM_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero
);

  localparam int QW    = 2 * DW;
  localparam int CNT_W = cnt_width(DW);

  div_state_t state, state_nxt;

  // shreg holds the unconsumed dividend bits in its top and collects quotient bits at the bottom
  logic [QW-1:0]    shreg;
  logic [DW-1:0]    divisor_q;
  // Partial remainder stays below divisor, so DW bits suffice; the DW+1-bit width lives in t
  logic [DW-1:0]    prem;
  logic [CNT_W-1:0] counter;

  logic             accept;
  logic             out_hs;
  logic             last_step;
  logic [DW:0]      t;
  logic [DW:0]      diff;
  logic             q_bit;
  logic [QW-1:0]    shreg_step;
  logic [DW-1:0]    prem_step;
  logic [QW-1:0]    shreg_init;
  logic [CNT_W-1:0] cnt_init;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_step = (counter == CNT_W'(1));

`ifdef IDDMM_DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lz;

  iddmm_lzc #(
    .W  (QW),
    .CW (CNT_W)
  ) u_lzc (
    .din   (dividend),
    .count (lz)
  );

  // Leading zeros would only produce leading zero quotient bits, so skip those iterations
  assign shreg_init = dividend << lz;
  assign cnt_init   = (lz == CNT_W'(QW)) ? CNT_W'(1) : (CNT_W'(QW) - lz);
`else
  assign shreg_init = dividend;
  assign cnt_init   = CNT_W'(QW);
`endif

  // One restoring step: bring down the next dividend bit, subtract if it fits
  always_comb begin
    t          = {prem, shreg[QW-1]};
    diff       = t - {1'b0, divisor_q};
    q_bit      = (t >= {1'b0, divisor_q});
    prem_step  = DW'(q_bit ? diff : t);
    shreg_step = {shreg[QW-2:0], q_bit};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: zero divisor bypasses the iteration entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (last_step) state_nxt = DONE;
      DONE: if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers; results only change when a new result is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      divisor_q <= '0;
      prem      <= '0;
      counter   <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            divisor_q <= divisor;
            prem      <= '0;
            shreg     <= shreg_init;
            if (divisor == '0) begin
              counter   <= '0;
              quotient  <= '1;
              remainder <= dividend[DW-1:0];
              div_zero  <= 1'b1;
            end else begin
              counter   <= cnt_init;
            end
          end
        end
        RUN: begin
          shreg   <= shreg_step;
          prem    <= prem_step;
          counter <= counter - CNT_W'(1);
          if (last_step) begin
            quotient  <= shreg_step;
            remainder <= prem_step;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // out_valid follows DONE by one cycle and drops on the output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= (state == DONE) && !out_hs;
  end

endmodule

// File: tb/tb_iddmm_div_256_by_128.sv
// tb/tb_iddmm_div_256_by_128.sv - randomized self-checking bench for iddmm_div_256_by_128
module tb_iddmm_div_256_by_128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] dividend = '0;
  logic [127:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] quotient;
  logic [127:0] remainder;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iddmm_div_256_by_128 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] ref_q(input logic [255:0] a, input logic [127:0] b);
    if (b == '0) return '1;
    return a / {128'd0, b};
  endfunction

  function automatic logic [127:0] ref_r(input logic [255:0] a, input logic [127:0] b);
    if (b == '0) return a[127:0];
    return 128'(a % {128'd0, b});
  endfunction

  // Cycles from the accept edge to the edge where out_valid is first seen high
  function automatic int ref_lat(input logic [255:0] a, input logic [127:0] b);
    int bits;
    if (b == '0) return 1;
    bits = 0;
    for (int i = 0; i < 256; i++) if (a[i]) bits = i + 1;
`ifdef IDDMM_DIV_EARLY_TERM_EN
    return ((bits > 1) ? bits : 1) + 1;
`else
    return 257 + (bits - bits);
`endif
  endfunction

  task automatic start_div(input logic [255:0] a, input logic [127:0] b);
    int g;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    g = 0;
    while (!in_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_div(input logic [255:0] a, input logic [127:0] b,
                        output logic [255:0] q, output logic [127:0] r,
                        output logic dz, output int lat);
    start_div(a, b);
    wait_result(lat);
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    release_result();
  endtask

  task automatic test_reset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    total++; if (remainder !== '0) begin bad++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
  endtask

  task automatic test_basic();
    logic [255:0] q; logic [127:0] r; logic dz; int lat;
    do_div(256'd100, 128'd7, q, r, dz, lat);
    total++; if (q !== 256'd14) begin bad++; $display("FAIL basic_q: got %0d want 14", q); end
    total++; if (r !== 128'd2) begin bad++; $display("FAIL basic_r: got %0d want 2", r); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL basic_dz: got %b want 0", dz); end
    total++; if (lat !== ref_lat(256'd100, 128'd7)) begin bad++; $display("FAIL basic_lat: got %0d want %0d", lat, ref_lat(256'd100, 128'd7)); end
  endtask

  task automatic test_product();
    logic [255:0] q, a256; logic [127:0] r, x, y; logic dz; int lat;
    for (int i = 0; i < 100; i++) begin
      x = rand128();
      y = rand128();
      if (y == '0) y = 128'd1;
      a256 = {128'd0, x} * {128'd0, y};
      do_div(a256, y, q, r, dz, lat);
      total++; if (q !== {128'd0, x}) begin bad++; $display("FAIL product_q[%0d]: got %h want %h", i, q, x); end
      total++; if (r !== '0) begin bad++; $display("FAIL product_r[%0d]: got %h want 0", i, r); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL product_dz[%0d]: got %b want 0", i, dz); end
      total++; if (lat !== ref_lat(a256, y)) begin bad++; $display("FAIL product_lat[%0d]: got %0d want %0d", i, lat, ref_lat(a256, y)); end
    end
  endtask

  task automatic test_random();
    logic [255:0] q, a; logic [127:0] r, b; logic dz; int lat;
    for (int i = 0; i < 30; i++) begin
      case (i % 4)
        0: begin a = {rand128(), rand128()}; b = rand128(); end
        1: begin b = rand128() | {1'b1, 127'd0}; a = {128'd0, 1'b0, rand128() >> 1}; end
        2: begin a = {rand128(), rand128()}; b = 128'($urandom_range(15, 1)); end
        default: begin a = 256'($urandom); b = rand128() >> $urandom_range(120, 0); end
      endcase
      if (b == '0) b = 128'd3;
      do_div(a, b, q, r, dz, lat);
      total++; if (q !== ref_q(a, b)) begin bad++; $display("FAIL random_q[%0d]: got %h want %h", i, q, ref_q(a, b)); end
      total++; if (r !== ref_r(a, b)) begin bad++; $display("FAIL random_r[%0d]: got %h want %h", i, r, ref_r(a, b)); end
      total++; if (lat !== ref_lat(a, b)) begin bad++; $display("FAIL random_lat[%0d]: got %0d want %0d", i, lat, ref_lat(a, b)); end
    end
  endtask

  task automatic test_div_zero();
    logic [255:0] q; logic [127:0] r; logic dz; int lat;
    do_div(256'h1234, 128'd0, q, r, dz, lat);
    total++; if (q !== {256{1'b1}}) begin bad++; $display("FAIL dz_q: got %h want all-ones", q); end
    total++; if (r !== 128'h1234) begin bad++; $display("FAIL dz_r: got %h want 1234", r); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", dz); end
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_lat: got %0d want 1", lat); end
  endtask

  task automatic test_edges();
    logic [255:0] q; logic [127:0] r; logic dz; int lat;
    do_div(256'd1, 128'd3, q, r, dz, lat);
    total++; if (q !== '0) begin bad++; $display("FAIL one_by_three_q: got %h want 0", q); end
    total++; if (r !== 128'd1) begin bad++; $display("FAIL one_by_three_r: got %h want 1", r); end
    total++; if (lat !== ref_lat(256'd1, 128'd3)) begin bad++; $display("FAIL one_by_three_lat: got %0d want %0d", lat, ref_lat(256'd1, 128'd3)); end
    do_div(256'd0, 128'd5, q, r, dz, lat);
    total++; if (q !== '0 || r !== '0) begin bad++; $display("FAIL zero_dividend: got q=%h r=%h want 0 0", q, r); end
    total++; if (lat !== ref_lat(256'd0, 128'd5)) begin bad++; $display("FAIL zero_dividend_lat: got %0d want %0d", lat, ref_lat(256'd0, 128'd5)); end
  endtask

  task automatic test_hold();
    logic [255:0] a, q; logic [127:0] b, r; logic dz; int lat;
    a = {rand128(), rand128()};
    b = rand128() | 128'd1;
    start_div(a, b);
    wait_result(lat);
    total++; if (lat !== ref_lat(a, b)) begin bad++; $display("FAIL hold_lat: got %0d want %0d", lat, ref_lat(a, b)); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== ref_q(a, b) || remainder !== ref_r(a, b)) begin
        bad++;
        $display("FAIL hold_stable[%0d]: got ov=%b ir=%b q=%h r=%h want ov=1 ir=0 q=%h r=%h",
                 i, out_valid, in_ready, quotient, remainder, ref_q(a, b), ref_r(a, b));
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL hold_release: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    total++; if (quotient !== ref_q(a, b)) begin bad++; $display("FAIL hold_after_release_q: got %h want %h", quotient, ref_q(a, b)); end
    do_div(256'd99, 128'd10, q, r, dz, lat);
    total++; if (q !== 256'd9 || r !== 128'd9) begin bad++; $display("FAIL hold_next: got q=%0d r=%0d want 9 9", q, r); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] a1, a2, q; logic [127:0] b1, b2; int lat;
    a1 = {rand128(), rand128()}; b1 = rand128() | 128'd1;
    a2 = {128'd0, rand128()};    b2 = 128'($urandom) | 128'd1;
    start_div(a1, b1);
    in_valid = 1'b1;
    dividend = a2;
    divisor  = b2;
    wait_result(lat);
    total++; if (quotient !== ref_q(a1, b1) || remainder !== ref_r(a1, b1)) begin bad++; $display("FAIL b2b_first: got q=%h r=%h want q=%h r=%h", quotient, remainder, ref_q(a1, b1), ref_r(a1, b1)); end
    release_result();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    q = quotient;
    total++; if (q !== ref_q(a2, b2) || remainder !== ref_r(a2, b2)) begin bad++; $display("FAIL b2b_second: got q=%h r=%h want q=%h r=%h", q, remainder, ref_q(a2, b2), ref_r(a2, b2)); end
    total++; if (lat !== ref_lat(a2, b2)) begin bad++; $display("FAIL b2b_second_lat: got %0d want %0d", lat, ref_lat(a2, b2)); end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic [255:0] q; logic [127:0] r; logic dz; int lat; int seen;
    start_div({rand128(), rand128()}, rand128() | 128'd1);
    repeat (99) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrun_ready: got %b want 0", in_ready); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0) begin bad++; $display("FAIL midrun_reset_state: got ir=%b ov=%b q=%h want 1 0 0", in_ready, out_valid, quotient); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrun_no_output: got %0d valid cycles want 0", seen); end
    do_div(256'd50, 128'd5, q, r, dz, lat);
    total++; if (q !== 256'd10 || r !== '0 || dz !== 1'b0) begin bad++; $display("FAIL midrun_next: got q=%0d r=%0d dz=%b want 10 0 0", q, r, dz); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_div_zero();
    test_edges();
    test_product();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
